// File: rtl/shared_wire_pkg.sv
// Shared types and helpers for the shared_wire_arbiter codebase slice.
package shared_wire_pkg;

  localparam int MAX_N = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Pointer width for n requesters, never narrower than one bit.
  function automatic int ptr_w_f(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_N-1:0] onehot_f(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/shared_wire_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at index >= ptr, wrapping.
module rr_pick
  import shared_wire_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             found
);

  logic [PTR_W-1:0] idx_s;

  // Scan from farthest to nearest offset so the nearest requester wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx_s  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s  = PTR_W'((int'(ptr) + k) % N);
      winner = req[idx_s] ? idx_s : winner;
      found  = found | req[idx_s];
    end
  end

endmodule

// File: rtl/shared_wire_arbiter.sv
// Burst-granular round-robin arbiter sharing one registered wire among N sources.
// Optional forced release after MAX_HOLD owned cycles: define SHARED_WIRE_TIMEOUT_EN.
module shared_wire_arbiter
  import shared_wire_pkg::*;
#(
  parameter int   N          = 4,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   MAX_HOLD   = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] din,
  input  logic [N-1:0] last,
  output logic [N-1:0] gnt,
  output logic         out,
  output logic         out_valid,
  output logic         busy,
  output logic         timeout
);

  localparam int PTR_W = ptr_w_f(N);

  state_t           state_r, state_s;
  logic [N-1:0]     gnt_r, gnt_s;
  logic [PTR_W-1:0] ptr_r, ptr_s;
  logic [PTR_W-1:0] owner_r, owner_s;
  logic             out_r, out_s;
  logic             valid_r, valid_s;
  logic             busy_r;

  logic             owner_req_s, owner_last_s, force_s, release_s;
  logic [PTR_W-1:0] next_ptr_s;
  logic [N-1:0]     hand_req_s;
  logic [PTR_W-1:0] idle_win_s, hand_win_s;
  logic             idle_found_s, hand_found_s;
  logic [MAX_N-1:0] idle_oh_s, hand_oh_s;

  assign owner_req_s  = req[owner_r];
  assign owner_last_s = last[owner_r];
  assign next_ptr_s   = (owner_r == PTR_W'(N - 1)) ? '0 : owner_r + PTR_W'(1);
  assign release_s    = (state_r == OWN) && (!owner_req_s || owner_last_s || force_s);
  // A forced release must not hand the wire straight back to the same owner.
  assign hand_req_s   = force_s ? (req & ~gnt_r) : req;
  assign idle_oh_s    = onehot_f(4'(idle_win_s));
  assign hand_oh_s    = onehot_f(4'(hand_win_s));

  rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick_idle (
    .req    (req),
    .ptr    (ptr_r),
    .winner (idle_win_s),
    .found  (idle_found_s)
  );

  rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick_hand (
    .req    (hand_req_s),
    .ptr    (next_ptr_s),
    .winner (hand_win_s),
    .found  (hand_found_s)
  );

`ifdef SHARED_WIRE_TIMEOUT_EN
  localparam int HOLD_W = ptr_w_f(MAX_HOLD);

  logic [HOLD_W-1:0] hold_r;
  logic              grant_load_s;
  logic              timeout_r;

  // The last of MAX_HOLD owned cycles still carries its bit; the release is then forced.
  assign force_s      = (state_r == OWN) && owner_req_s && !owner_last_s &&
                        (hold_r == HOLD_W'(MAX_HOLD - 1));
  assign grant_load_s = ((state_r == IDLE) && idle_found_s) || (release_s && hand_found_s);
  assign timeout      = timeout_r;

  // Hold counter: cleared on every grant, counts owned cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r    <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= force_s;
      if (grant_load_s) begin
        hold_r <= '0;
      end else if (state_r == OWN) begin
        hold_r <= hold_r + HOLD_W'(1);
      end else begin
        hold_r <= hold_r;
      end
    end
  end
`else
  // Ownership is unbounded; MAX_HOLD matters only to the optional hold counter.
  assign force_s = (MAX_HOLD < 0);
  assign timeout = 1'b0;
`endif

  // Next-state, grant and wire data selection.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    owner_s = owner_r;
    ptr_s   = ptr_r;
    out_s   = IDLE_LEVEL;
    valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (idle_found_s) begin
          state_s = OWN;
          owner_s = idle_win_s;
          gnt_s   = idle_oh_s[N-1:0];
        end else begin
          gnt_s = '0;
        end
      end
      OWN: begin
        if (owner_req_s) begin
          out_s   = din[owner_r];
          valid_s = 1'b1;
        end else begin
          out_s   = IDLE_LEVEL;
          valid_s = 1'b0;
        end
        if (release_s) begin
          ptr_s = next_ptr_s;
          if (hand_found_s) begin
            owner_s = hand_win_s;
            gnt_s   = hand_oh_s[N-1:0];
          end else begin
            state_s = IDLE;
            gnt_s   = '0;
          end
        end else begin
          gnt_s = gnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      ptr_r   <= '0;
      owner_r <= '0;
      out_r   <= IDLE_LEVEL;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      out_r   <= out_s;
      valid_r <= valid_s;
      busy_r  <= (state_s == OWN);
    end
  end

  assign gnt       = gnt_r;
  assign out       = out_r;
  assign out_valid = valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_shared_wire_arbiter.sv
// Directed bench for shared_wire_arbiter with a burst-level reference model.
module tb_shared_wire_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'd0;
  logic [3:0] din   = 4'd0;
  logic [3:0] last  = 4'd0;
  logic [3:0] gnt;
  logic       out, out_valid, busy, timeout;

  int checks = 0;
  int errors = 0;

  shared_wire_arbiter #(.N(N), .IDLE_LEVEL(1'b0), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .last      (last),
    .gnt       (gnt),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] l);
    @(negedge clk);
    req  = r;
    din  = d;
    last = l;
  endtask

  // Reference model: who owns the wire, where the pointer is, what the wire carries.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_hold  = 0;
  logic [3:0] m_gnt   = 4'd0;
  logic       m_out   = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_busy  = 1'b0;
  logic       m_to    = 1'b0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int o, nxt, np;
    bit rel, frc;
    if (!rst_n) begin
      m_owner <= -1; m_ptr <= 0; m_hold <= 0; m_gnt <= 4'd0;
      m_out <= 1'b0; m_valid <= 1'b0; m_busy <= 1'b0; m_to <= 1'b0;
    end else begin
      o = m_owner; np = m_ptr; rel = 1'b0; frc = 1'b0;
      m_out <= 1'b0; m_valid <= 1'b0;
      if (o < 0) begin
        nxt = pick(req, m_ptr);
      end else begin
`ifdef SHARED_WIRE_TIMEOUT_EN
        frc = (m_hold == MAXH - 1) && req[o] && !last[o];
`endif
        if (req[o]) begin
          m_out <= din[o]; m_valid <= 1'b1;
        end
        rel = !req[o] || last[o] || frc;
        nxt = o;
        if (rel) begin
          np  = (o + 1) % N;
          nxt = pick(frc ? (req & ~(4'b0001 << o)) : req, np);
        end
      end
      m_to    <= frc;
      m_ptr   <= np;
      m_hold  <= (nxt >= 0 && (o < 0 || rel)) ? 0 : m_hold + 1;
      m_owner <= nxt;
      m_gnt   <= (nxt >= 0) ? (4'b0001 << nxt) : 4'd0;
      m_busy  <= (nxt >= 0);
    end
  end

  logic [3:0] prev_gnt = 4'd0;
  int         glog[$];
  logic       obits[$];
  int         to_cnt = 0;

  // Every-cycle comparison against the model, plus grant/bit/timeout logging.
  always @(negedge clk) begin
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("out", 32'(out), 32'(m_out));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("timeout", 32'(timeout), 32'(m_to));
    if (gnt != prev_gnt && gnt != 4'd0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) glog.push_back(i);
    end
    if (out_valid) obits.push_back(out);
    if (timeout) to_cnt++;
    prev_gnt = gnt;
  end

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a burst on requester 2.
    step(4'b0100, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    chk("grant2_latency", 32'(gnt), 32'h4);
    step(4'b0100, 4'b0100, 4'b0000);
    @(posedge clk); #2;
    chk("pre_reset_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    req = 4'd0; din = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single 3-bit burst 1,0,1; stray last bits on non-requesters.
    @(posedge clk); #1;
    obits.delete();
    step(4'b0100, 4'b0000, 4'b0000);
    step(4'b0100, 4'b0100, 4'b1001);
    step(4'b0100, 4'b0000, 4'b0000);
    step(4'b0100, 4'b0100, 4'b0100);
    step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    chk("burst_bits", 32'(obits.size()), 32'd3);
    if (obits.size() == 3) begin
      chk("burst_b0", 32'(obits[0]), 32'h1);
      chk("burst_b1", 32'(obits[1]), 32'h0);
      chk("burst_b2", 32'(obits[2]), 32'h1);
    end
    chk("burst_idle_gnt", 32'(gnt), 32'h0);

    // Pointer now at 3: requester 0 wins by wrap, then aborts mid-burst.
    step(4'b0001, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    chk("wrap_gnt", 32'(gnt), 32'h1);
    step(4'b0001, 4'b0001, 4'b0000);
    step(4'b0000, 4'b0001, 4'b0000);
    @(posedge clk); #1;
    chk("abort_valid", 32'(out_valid), 32'h0);
    chk("abort_gnt", 32'(gnt), 32'h0);

    // Fairness from ptr=0: all four request, 2-bit bursts.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1; glog.delete();
    step(4'b1111, 4'b0000, 4'b0000);
    for (int b = 0; b < 5; b++) begin
      step(4'b1111, 4'b1010, 4'b0000);
      step(4'b1111, 4'b0101, 4'b1111);
    end
    step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    chk("fair_len_ok", 32'(glog.size() >= 5), 32'h1);
    if (glog.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("fair_order", 32'(glog[i]), 32'(exp_order[i]));
    end

    // One-bit bursts from requester 1 alone: continuous re-grant.
    for (int i = 0; i < 5; i++) step(4'b0010, (i % 2) ? 4'b0010 : 4'b0000, 4'b0010);
    @(posedge clk); #1;
    chk("onebit_gnt", 32'(gnt), 32'h2);
    chk("onebit_valid", 32'(out_valid), 32'h1);
    step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);

`ifdef SHARED_WIRE_TIMEOUT_EN
    // Requester 0 never ends its burst; requester 1 pending.
    @(posedge clk); #1;
    glog.delete();
    for (int i = 0; i < 12; i++) step(4'b0011, 4'b0001, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    chk("timeout_pulses", 32'(to_cnt), 32'd1);
    chk("timeout_glog_len", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) chk("timeout_handoff", 32'(glog[1]), 32'd1);
`else
    @(posedge clk); #1;
    chk("timeout_never", 32'(to_cnt), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
